mvm_seq: RTL and testbench

Sequencer that feeds the matrix-vector MAC array, which computes all N row dot-products in parallel and shifts them out serially. It accepts a byte-serial stream of vector and matrix elements and assembles them one column at a time. It issues each column to the array with init/accumulate control, then drains the array's serial result chain into a local buffer. It re-emits the N results as a valid/ready stream with backpressure.

---
 rtl/mvm_seq_pkg.sv | 21 ++
 rtl/mvm_res_buf.sv | 68 ++++++
 rtl/mvm_seq.sv | 173 +++++++++++++++++
 tb/tb_mvm_seq.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvm_seq_pkg.sv
// mvm_seq_pkg
//   Shared types and helpers for the matrix-vector sequencer.
//   - state_t : sequencer states
//   - res_w() : result width of one row dot-product (2*DW + log2(N) bits)
package mvm_seq_pkg;

   typedef enum logic [2:0] {
      FILL  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      LOAD  = 3'd3,
      DRAIN = 3'd4,
      EMIT  = 3'd5
   } state_t;

   // A sum of N products of two DW-bit values never exceeds this width.
   function automatic int res_w(input int n, input int dw);
      return 2 * dw + $clog2(n);
   endfunction

endpackage

// File: rtl/mvm_res_buf.sv
// mvm_res_buf
//   N-entry capture buffer for the array's serial result chain, replayed
//   as a valid/ready stream.
//   Ports:
//     clk, rst          clock, async active-low reset
//     i_wr_en           one result per cycle while draining the chain
//     i_wr_data         array serial result
//     i_rd_en           buffer is being emitted (presents out_valid)
//     i_rd_ready        downstream ready
//     o_rd_valid        stream valid
//     o_rd_data         current result y[rptr]
//     o_rd_last         current beat is y[N-1]
//     o_rd_done         last beat accepted this cycle
module mvm_res_buf
   import mvm_seq_pkg::*;
#(
   parameter int N  = 3,
   parameter int RW = 18
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_wr_en,
   input  logic [RW-1:0] i_wr_data,
   input  logic          i_rd_en,
   input  logic          i_rd_ready,
   output logic          o_rd_valid,
   output logic [RW-1:0] o_rd_data,
   output logic          o_rd_last,
   output logic          o_rd_done
);

   localparam int IW = $clog2(N);

   logic [RW-1:0] r_buf [0:N-1];
   logic [IW-1:0] r_wptr;
   logic [IW-1:0] r_rptr;
   logic          w_rlast;
   logic          w_take;

   assign w_rlast = (r_rptr == IW'(N - 1));
   assign w_take  = i_rd_en & i_rd_ready;

   // Write side: pointer wraps after N entries, so it is back at 0 for the
   // next job without any explicit clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N; i++) r_buf[i] <= '0;
         r_wptr <= '0;
      end else if (i_wr_en) begin
         r_buf[r_wptr] <= i_wr_data;
         r_wptr        <= (r_wptr == IW'(N - 1)) ? '0 : r_wptr + 1'b1;
      end
   end

   // Read side: advances only on a handshake, so data holds while stalled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_rptr <= '0;
      else if (w_take)
         r_rptr <= w_rlast ? '0 : r_rptr + 1'b1;
   end

   assign o_rd_valid = i_rd_en;
   assign o_rd_data  = i_rd_en ? r_buf[r_rptr] : '0;
   assign o_rd_last  = i_rd_en & w_rlast;
   assign o_rd_done  = w_take & w_rlast;

endmodule

// File: rtl/mvm_seq.sv
// mvm_seq
//   Sequencer for an N x N matrix-vector MAC array. Collects a byte-serial
//   stream (per column k: b[k], A[0][k] .. A[N-1][k]), issues each column to
//   the array, drains the array's serial result chain into mvm_res_buf and
//   replays y[0..N-1] as a valid/ready stream.
//   Ports:
//     clk, rst                      clock, async active-low reset
//     in_valid/in_ready/in_data     element input stream
//     arr_col, arr_vect             registered column of A and b[k]
//     arr_init, arr_acc_en          column issue strobes
//     arr_shift_en                  0 = chain reload, 1 = chain shift
//     arr_result                    array serial result
//     out_valid/out_ready/out_data  result stream, out_last on y[N-1]
//     busy                          job in progress
module mvm_seq
   import mvm_seq_pkg::*;
#(
   parameter  int N   = 3,
   parameter  int DW  = 8,
   parameter  int LAT = 1,
   localparam int RW  = res_w(N, DW)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic [DW-1:0] arr_col [0:N-1],
   output logic [DW-1:0] arr_vect,
   output logic          arr_init,
   output logic          arr_acc_en,
   output logic          arr_shift_en,
   input  logic [RW-1:0] arr_result,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [RW-1:0] out_data,
   output logic          out_last,
   output logic          busy
);

   localparam int CW        = $clog2(N + 1);
   localparam int KW        = $clog2(N);
   localparam int WTW       = (LAT > 1) ? $clog2(LAT) : 1;
   localparam int WAIT_INIT = (LAT > 0) ? LAT - 1 : 0;

   state_t         r_state;
   state_t         w_next;
   logic [CW-1:0]  r_cnt;      // word index in FILL, drain index in DRAIN
   logic [KW-1:0]  r_k;        // column index
   logic [WTW-1:0] r_wait;
   logic [DW-1:0]  r_vbuf;
   logic [DW-1:0]  r_colbuf [0:N-2];

   logic w_accept;
   logic w_col_done;
   logic w_last_col;
   logic w_drain_done;
   logic w_wr_en;
   logic w_rd_en;
   logic w_emit_done;

   assign w_accept     = in_valid & in_ready;
   assign w_col_done   = w_accept & (r_cnt == CW'(N));
   assign w_last_col   = (r_k == KW'(N - 1));
   assign w_drain_done = (r_cnt == CW'(N - 1));

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= FILL;
      else      r_state <= w_next;
   end

   // ---------------- next state ----------------
   always_comb begin
      w_next = r_state;
      case (r_state)
         FILL:    if (w_col_done) w_next = ISSUE;
         ISSUE: begin
            if (w_last_col) w_next = (LAT == 0) ? LOAD : WAIT;
            else            w_next = FILL;
         end
         WAIT:    if (r_wait == '0) w_next = LOAD;
         LOAD:    w_next = DRAIN;
         DRAIN:   if (w_drain_done) w_next = EMIT;
         EMIT:    if (w_emit_done) w_next = FILL;
         default: w_next = FILL;
      endcase
   end

   // ---------------- state outputs ----------------
   // In LOAD shift_en stays 0, which is what makes the chain capture the
   // row sums; the first DRAIN cycle then presents y[0].
   always_comb begin
      in_ready     = 1'b0;
      arr_acc_en   = 1'b0;
      arr_init     = 1'b0;
      arr_shift_en = 1'b0;
      w_wr_en      = 1'b0;
      w_rd_en      = 1'b0;
      case (r_state)
         FILL:  in_ready = 1'b1;
         ISSUE: begin
            arr_acc_en = 1'b1;
            arr_init   = (r_k == '0);
         end
         DRAIN: begin
            arr_shift_en = 1'b1;
            w_wr_en      = 1'b1;
         end
         EMIT:  w_rd_en = 1'b1;
         default: ;
      endcase
   end

   // ---------------- column assembly and counters ----------------
   // The column register fills independently of arr_col/arr_vect, which only
   // change on the edge that enters ISSUE. The final element of a column
   // goes straight to arr_col[N-1] so no extra cycle is spent.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt    <= '0;
         r_k      <= '0;
         r_wait   <= '0;
         r_vbuf   <= '0;
         arr_vect <= '0;
         for (int i = 0; i < N - 1; i++) r_colbuf[i] <= '0;
         for (int i = 0; i < N; i++)     arr_col[i]  <= '0;
      end else begin
         case (r_state)
            FILL: begin
               if (w_accept) begin
                  if (r_cnt == CW'(N)) begin
                     r_cnt        <= '0;
                     arr_vect     <= r_vbuf;
                     arr_col[N-1] <= in_data;
                     for (int i = 0; i < N - 1; i++) arr_col[i] <= r_colbuf[i];
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                     if (r_cnt == '0) r_vbuf <= in_data;
                     for (int i = 0; i < N - 1; i++)
                        if (r_cnt == CW'(i + 1)) r_colbuf[i] <= in_data;
                  end
               end
            end
            ISSUE: begin
               r_k    <= w_last_col ? '0 : r_k + 1'b1;
               r_wait <= WTW'(WAIT_INIT);
            end
            WAIT:  r_wait <= r_wait - 1'b1;
            DRAIN: r_cnt  <= w_drain_done ? '0 : r_cnt + 1'b1;
            EMIT:  if (w_emit_done) r_k <= '0;
            default: ;
         endcase
      end
   end

   // Idle means FILL with nothing collected yet.
   assign busy = (r_state != FILL) | (r_cnt != '0) | (r_k != '0);

   mvm_res_buf #(.N(N), .RW(RW)) u_res_buf (
      .clk        (clk),
      .rst        (rst),
      .i_wr_en    (w_wr_en),
      .i_wr_data  (arr_result),
      .i_rd_en    (w_rd_en),
      .i_rd_ready (out_ready),
      .o_rd_valid (out_valid),
      .o_rd_data  (out_data),
      .o_rd_last  (out_last),
      .o_rd_done  (w_emit_done)
   );

endmodule

// File: tb/tb_mvm_seq.sv
// tb_mvm_seq
//   Three sequencer instances (LAT = 1, 0, 3), each driving a behavioural
//   MAC array: sums update on acc_en, row outputs are the sums delayed LAT
//   cycles, and a shift chain reloads when shift_en=0 and shifts toward
//   arr_result when shift_en=1.
module tb_mvm_seq;
   localparam int N  = 3;
   localparam int DW = 8;
   localparam int RW = 18;
   localparam int NI = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [NI-1:0] iv, ir, acc, init, shf, ov, ordy, ol, bz, colz;
   logic [DW-1:0] idat [NI];
   logic [RW-1:0] od   [NI];

   int errors = 0;
   int checks = 0;

   // monitor state, single writer
   int cyc;
   int acc_n [NI], init_n [NI], init_at [NI], last_iss [NI], iss_gap [NI];
   int first_shf [NI], first_ov [NI], rdy_viol [NI];
   logic [NI-1:0] shf_d, ov_d;

   for (genvar g = 0; g < NI; g++) begin : gi
      localparam int LV = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
      logic [DW-1:0] col [0:N-1];
      logic [DW-1:0] vect;
      logic [RW-1:0] res, o_d;
      logic [RW-1:0] sum   [0:N-1];
      logic [RW-1:0] rows  [0:N-1];
      logic [RW-1:0] chain [0:N-1];
      logic a_i, a_a, a_s, i_r, o_v, o_l, b_z;

      mvm_seq #(.N(N), .DW(DW), .LAT(LV)) dut (
         .clk(clk), .rst(rst), .in_valid(iv[g]), .in_ready(i_r), .in_data(idat[g]),
         .arr_col(col), .arr_vect(vect), .arr_init(a_i), .arr_acc_en(a_a),
         .arr_shift_en(a_s), .arr_result(res), .out_valid(o_v), .out_ready(ordy[g]),
         .out_data(o_d), .out_last(o_l), .busy(b_z));

      assign ir[g]   = i_r;
      assign acc[g]  = a_a;
      assign init[g] = a_i;
      assign shf[g]  = a_s;
      assign ov[g]   = o_v;
      assign ol[g]   = o_l;
      assign bz[g]   = b_z;
      assign od[g]   = o_d;
      assign colz[g] = (col[0] == '0) && (col[1] == '0) && (col[2] == '0) && (vect == '0);
      assign res     = chain[0];

      always @(posedge clk) begin
         if (a_a)
            for (int i = 0; i < N; i++)
               sum[i] <= (a_i ? RW'(0) : sum[i]) + RW'(col[i]) * RW'(vect);
         for (int i = 0; i < N - 1; i++) chain[i] <= a_s ? chain[i+1] : rows[i];
         chain[N-1] <= a_s ? RW'(0) : rows[N-1];
      end

      if (LV == 0) begin : gp0
         always_comb rows = sum;
      end else begin : gp
         logic [RW-1:0] dly [1:LV][0:N-1];
         always @(posedge clk) begin
            dly[1] <= sum;
            for (int l = 2; l <= LV; l++) dly[l] <= dly[l-1];
         end
         always_comb rows = dly[LV];
      end
   end

   always @(negedge clk) begin
      cyc <= cyc + 1;
      for (int g = 0; g < NI; g++) begin
         if (acc[g]) begin
            acc_n[g]    <= acc_n[g] + 1;
            iss_gap[g]  <= cyc - last_iss[g];
            last_iss[g] <= cyc;
            if (init[g]) begin
               init_n[g]  <= init_n[g] + 1;
               init_at[g] <= acc_n[g];
            end
         end
         if (shf[g] && !shf_d[g]) first_shf[g] <= cyc;
         if (ov[g] && !ov_d[g])   first_ov[g]  <= cyc;
         if (ir[g] && (acc[g] || shf[g] || ov[g])) rdy_viol[g] <= rdy_viol[g] + 1;
      end
      shf_d <= shf;
      ov_d  <= ov;
   end

   // matrices, row-major
   int ma   [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
   int m255 [9] = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
   int mid  [9] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
   int b111 [3] = '{1, 1, 1};
   int b123 [3] = '{1, 2, 3};
   int b010 [3] = '{0, 1, 0};
   int b255 [3] = '{255, 255, 255};
   int b567 [3] = '{5, 6, 7};

   // ---------------- drivers (called on a falling edge) ----------------
   task automatic push(input int g, input int w, output bit tmo);
      int t;
      t = 0;
      iv[g]   = 1'b1;
      idat[g] = DW'(w);
      while (ir[g] !== 1'b1 && t < 200) begin @(negedge clk); t++; end
      tmo = (t >= 200);
      @(negedge clk);
      iv[g] = 1'b0;
   endtask

   task automatic send_job(input int g, input int a [9], input int b [3], input bit gaps,
                           output bit tmo);
      bit t1;
      int w;
      tmo = 1'b0;
      for (int k = 0; k < N; k++)
         for (int i = -1; i < N; i++) begin
            if (i < 0) w = b[k];
            else       w = a[i*N + k];
            push(g, w, t1);
            tmo |= t1;
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
         end
   endtask

   task automatic collect(input int g, output logic [RW-1:0] d [N], output logic [N-1:0] l,
                          output bit tmo);
      int t;
      tmo = 1'b0;
      ordy[g] = 1'b1;
      for (int j = 0; j < N; j++) begin
         t = 0;
         while (ov[g] !== 1'b1 && t < 100) begin @(negedge clk); t++; end
         if (t >= 100) begin
            tmo = 1'b1; d[j] = 'x; l[j] = 1'bx;
         end else begin
            d[j] = od[g]; l[j] = ol[g];
         end
         @(negedge clk);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      for (int g = 0; g < NI; g++) begin
         checks++;
         if ({ir[g], colz[g], acc[g], init[g], shf[g], ov[g], ol[g], bz[g]} !== 8'b11000000 ||
             od[g] !== '0) begin
            errors++;
            $display("FAIL reset_values[%0d]: got rdy/colz/acc/init/shf/ov/last/busy=%b data=%0d, expected 11000000 data=0",
                     g, {ir[g], colz[g], acc[g], init[g], shf[g], ov[g], ol[g], bz[g]}, od[g]);
         end
      end
   endtask

   task automatic test_basic;
      int ev [3] = '{6, 15, 24};
      logic [RW-1:0] got [N];
      logic [N-1:0] l;
      bit t1, t2;
      int a0, i0;
      a0 = acc_n[0]; i0 = init_n[0];
      send_job(0, ma, b111, 1'b0, t1);
      checks++;
      if (bz[0] !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", bz[0]); end
      collect(0, got, l, t2);
      for (int j = 0; j < N; j++) begin
         checks++;
         if (t1 || t2 || got[j] !== RW'(ev[j])) begin
            errors++; $display("FAIL basic_y%0d: got %0d expected %0d", j, got[j], ev[j]);
         end
      end
      checks++;
      if (l !== 3'b100) begin errors++; $display("FAIL basic_last: got %b expected 100", l); end
      checks++;
      if (acc_n[0] - a0 != 3 || init_n[0] - i0 != 1 || init_at[0] != a0) begin
         errors++;
         $display("FAIL basic_strobes: got acc=%0d init=%0d init_at=%0d expected acc=3 init=1 init_at=%0d",
                  acc_n[0] - a0, init_n[0] - i0, init_at[0], a0);
      end
      checks++;
      if (iss_gap[0] != N + 2) begin
         errors++; $display("FAIL basic_col_rate: got %0d expected %0d", iss_gap[0], N + 2);
      end
      checks++;
      if (first_ov[0] - last_iss[0] != 1 + N + 2) begin
         errors++; $display("FAIL basic_latency: got %0d expected %0d", first_ov[0] - last_iss[0], N + 3);
      end
      checks++;
      if (ov[0] !== 1'b0 || bz[0] !== 1'b0 || ir[0] !== 1'b1) begin
         errors++; $display("FAIL basic_idle: got valid=%b busy=%b rdy=%b expected 0 0 1", ov[0], bz[0], ir[0]);
      end
   endtask

   task automatic test_max;
      logic [RW-1:0] got [N];
      logic [N-1:0] l;
      bit t1, t2;
      send_job(0, m255, b255, 1'b0, t1);
      collect(0, got, l, t2);
      for (int j = 0; j < N; j++) begin
         checks++;
         if (t1 || t2 || got[j] !== RW'(195075)) begin
            errors++; $display("FAIL max_y%0d: got %0d expected 195075", j, got[j]);
         end
      end
   endtask

   task automatic test_backpressure;
      int ev [3] = '{14, 32, 50};
      logic [3:0] pat;
      int j, c, t;
      bit tmo;
      pat = 4'b1001;
      j = 0; c = 0; t = 0;
      ordy[0] = 1'b0;
      send_job(0, ma, b123, 1'b0, tmo);
      while (ov[0] !== 1'b1 && t < 100) begin @(negedge clk); t++; end
      checks++;
      if (t >= 100 || tmo) begin errors++; $display("FAIL bp_start: got timeout expected out_valid"); end
      while (j < N && c < 20) begin
         ordy[0] = pat[c % 4];
         checks++;
         if (ov[0] !== 1'b1 || od[0] !== RW'(ev[j]) || ol[0] !== (j == N - 1) || bz[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_beat%0d_c%0d: got valid=%b data=%0d last=%b busy=%b expected 1 %0d %b 1",
                     j, c, ov[0], od[0], ol[0], bz[0], ev[j], (j == N - 1));
         end
         if (pat[c % 4]) j++;
         c++;
         @(negedge clk);
      end
      ordy[0] = 1'b0;
      checks++;
      if (j != N || bz[0] !== 1'b0 || ov[0] !== 1'b0) begin
         errors++; $display("FAIL bp_end: got beats=%0d busy=%b valid=%b expected %0d 0 0", j, bz[0], ov[0], N);
      end
   endtask

   task automatic test_gaps;
      int ev1 [3] = '{6, 15, 24};
      int ev2 [3] = '{2, 5, 8};
      logic [RW-1:0] g1 [N];
      logic [RW-1:0] g2 [N];
      logic [N-1:0] l1, l2;
      bit t1, t2, t3, t4;
      int v0;
      v0 = rdy_viol[0];
      send_job(0, ma, b111, 1'b1, t1);
      // next job's first element is held valid through ISSUE..EMIT
      fork
         send_job(0, ma, b010, 1'b0, t2);
         collect(0, g1, l1, t3);
      join
      collect(0, g2, l2, t4);
      for (int j = 0; j < N; j++) begin
         checks++;
         if (t1 || t3 || g1[j] !== RW'(ev1[j])) begin
            errors++; $display("FAIL gaps_job1_y%0d: got %0d expected %0d", j, g1[j], ev1[j]);
         end
         checks++;
         if (t2 || t4 || g2[j] !== RW'(ev2[j])) begin
            errors++; $display("FAIL gaps_job2_y%0d: got %0d expected %0d", j, g2[j], ev2[j]);
         end
      end
      checks++;
      if (l1 !== 3'b100 || l2 !== 3'b100) begin
         errors++; $display("FAIL gaps_last: got %b %b expected 100 100", l1, l2);
      end
      checks++;
      if (rdy_viol[0] != v0) begin
         errors++; $display("FAIL gaps_in_ready: got %0d cycles ready outside FILL expected 0", rdy_viol[0] - v0);
      end
   endtask

   task automatic test_reset_mid_drain;
      int ev [3] = '{5, 6, 7};
      logic [RW-1:0] got [N];
      logic [N-1:0] l;
      bit t1, t2;
      int t, nv;
      t = 0; nv = 0;
      ordy[0] = 1'b0;
      send_job(0, ma, b111, 1'b0, t1);
      while (shf[0] !== 1'b1 && t < 100) begin @(negedge clk); t++; end
      @(negedge clk);
      checks++;
      if (t >= 100 || t1 || shf[0] !== 1'b1) begin
         errors++; $display("FAIL rst_drain_reach: got shift_en=%b expected 1", shf[0]);
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({ir[0], colz[0], acc[0], init[0], shf[0], ov[0], ol[0], bz[0]} !== 8'b11000000 || od[0] !== '0) begin
         errors++;
         $display("FAIL rst_drain_values: got rdy/colz/acc/init/shf/ov/last/busy=%b data=%0d, expected 11000000 data=0",
                  {ir[0], colz[0], acc[0], init[0], shf[0], ov[0], ol[0], bz[0]}, od[0]);
      end
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      repeat (6) begin @(negedge clk); if (ov[0] !== 1'b0) nv++; end
      checks++;
      if (nv != 0 || ir[0] !== 1'b1) begin
         errors++; $display("FAIL rst_drain_stale: got %0d valid cycles rdy=%b expected 0 and 1", nv, ir[0]);
      end
      send_job(0, mid, b567, 1'b0, t1);
      collect(0, got, l, t2);
      for (int j = 0; j < N; j++) begin
         checks++;
         if (t1 || t2 || got[j] !== RW'(ev[j])) begin
            errors++; $display("FAIL rst_fresh_y%0d: got %0d expected %0d", j, got[j], ev[j]);
         end
      end
      checks++;
      if (l !== 3'b100) begin errors++; $display("FAIL rst_fresh_last: got %b expected 100", l); end
   endtask

   task automatic test_latency;
      logic [RW-1:0] got [N];
      logic [N-1:0] l;
      bit t1, t2;
      int lat;
      for (int g = 1; g < NI; g++) begin
         lat = (g == 1) ? 0 : 3;
         send_job(g, ma, b111, 1'b0, t1);
         collect(g, got, l, t2);
         checks++;
         if (t1 || t2 || got[0] !== RW'(6) || got[1] !== RW'(15) || got[2] !== RW'(24) || l !== 3'b100) begin
            errors++;
            $display("FAIL lat%0d_results: got %0d %0d %0d last=%b expected 6 15 24 last=100",
                     lat, got[0], got[1], got[2], l);
         end
         checks++;
         if (first_shf[g] - last_iss[g] != lat + 2) begin
            errors++; $display("FAIL lat%0d_load: got drain start %0d expected %0d", lat, first_shf[g] - last_iss[g], lat + 2);
         end
         checks++;
         if (first_ov[g] - last_iss[g] != lat + N + 2) begin
            errors++; $display("FAIL lat%0d_first_valid: got %0d expected %0d", lat, first_ov[g] - last_iss[g], lat + N + 2);
         end
      end
   endtask

   initial begin
      rst  = 1'b0;
      iv   = '0;
      ordy = '0;
      for (int g = 0; g < NI; g++) idat[g] = '0;
      @(negedge clk); @(negedge clk);
      test_reset;
      rst = 1'b1;
      @(negedge clk);
      test_basic;
      test_max;
      test_backpressure;
      test_gaps;
      test_reset_mid_drain;
      test_latency;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
